// File: rtl/pipe_control_unit.sv
// ---------------------------------------------------------------------------
// pipe_control_unit
//
// Pipelined control unit for a small ARM-like core. Decodes the instruction in
// Decode, then carries the control word through Execute (_p0), Memory (_p1)
// and Writeback (_p2). Execute evaluates the condition field against a
// {N,Z,C,V} flags register and squashes side effects of instructions whose
// condition fails.
//
// Optional feature: define COND_EXEC_EN to enable conditional execution.
// Without it every instruction executes (CondExE = 1), the Cond field is
// ignored, and the flags register still updates from FlagWrite.
//
// Parameters
//   ALUCTRL_W    ALU control output width (3..8)
//   FLAG_W       condition flag width (4: N,Z,C,V)
//
// Ports
//   clk          clock, all state on rising edge
//   reset        asynchronous active-low reset
//   Op, Funct    instruction bits [27:26] and [25:20]
//   Rd           destination register field
//   Cond         condition field, instruction bits [31:28]
//   ALUFlags     {N,Z,C,V} produced by the ALU in Execute
//   StallE       hold the Execute control register
//   FlushE       replace Execute contents with a bubble (wins over StallE)
//   ImmSrcD      Decode immediate-extend select (combinational)
//   RegSrcD      Decode register-read select (combinational)
//   ALUControlE, ALUSrcE, MemtoRegE, BranchTakenE   Execute controls
//   RegWriteM, MemWriteM, MemtoRegM                 Memory controls
//   RegWriteW, MemtoRegW, PCSrcW                    Writeback controls
//   PCWrPending  a PC write is in flight in D, E or M
// ---------------------------------------------------------------------------
module pipe_control_unit #(
    parameter int ALUCTRL_W = 3,
    parameter int FLAG_W    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           Op,
    input  logic [5:0]           Funct,
    input  logic [3:0]           Rd,
    input  logic [3:0]           Cond,
    input  logic [FLAG_W-1:0]    ALUFlags,
    input  logic                 StallE,
    input  logic                 FlushE,
    output logic [1:0]           ImmSrcD,
    output logic [1:0]           RegSrcD,
    output logic [ALUCTRL_W-1:0] ALUControlE,
    output logic                 ALUSrcE,
    output logic                 MemtoRegE,
    output logic                 BranchTakenE,
    output logic                 RegWriteM,
    output logic                 MemWriteM,
    output logic                 MemtoRegM,
    output logic                 RegWriteW,
    output logic                 MemtoRegW,
    output logic                 PCSrcW,
    output logic                 PCWrPending
);

    localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(0);
    localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(1);
    localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(2);
    localparam logic [ALUCTRL_W-1:0] ALU_ORR = ALUCTRL_W'(3);
    localparam logic [ALUCTRL_W-1:0] ALU_MOV = ALUCTRL_W'(4);

    // Data-processing command field Funct[4:1]
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    logic                 reg_write_d;
    logic                 mem_write_d;
    logic                 mem_to_reg_d;
    logic                 branch_d;
    logic                 alu_src_d;
    logic                 pc_src_d;
    logic [1:0]           flag_write_d;
    logic [ALUCTRL_W-1:0] alu_control_d;
    logic [1:0]           imm_src_d;
    logic [1:0]           reg_src_d;
    logic                 dp_known;
    logic                 dp_arith;

    logic                 reg_write_p0;
    logic                 mem_write_p0;
    logic                 mem_to_reg_p0;
    logic                 branch_p0;
    logic                 alu_src_p0;
    logic                 pc_src_p0;
    logic [1:0]           flag_write_p0;
    logic [ALUCTRL_W-1:0] alu_control_p0;

    logic                 reg_write_p1;
    logic                 mem_write_p1;
    logic                 mem_to_reg_p1;
    logic                 pc_src_p1;

    logic                 reg_write_p2;
    logic                 mem_to_reg_p2;
    logic                 pc_src_p2;

    logic [FLAG_W-1:0]    flags_q;
    logic                 cond_ex_e;

    // ---------------- Decode (combinational) ----------------
    always_comb begin
        reg_write_d   = 1'b0;
        mem_write_d   = 1'b0;
        mem_to_reg_d  = 1'b0;
        branch_d      = 1'b0;
        alu_src_d     = 1'b0;
        flag_write_d  = 2'b00;
        alu_control_d = ALU_ADD;
        imm_src_d     = 2'b00;
        reg_src_d     = 2'b00;
        dp_known      = 1'b0;
        dp_arith      = 1'b0;

        case (Op)
            2'b00: begin
                case (Funct[4:1])
                    CMD_ADD: begin
                        dp_known = 1'b1; dp_arith = 1'b1;
                        reg_write_d = 1'b1; alu_control_d = ALU_ADD;
                    end
                    CMD_SUB: begin
                        dp_known = 1'b1; dp_arith = 1'b1;
                        reg_write_d = 1'b1; alu_control_d = ALU_SUB;
                    end
                    CMD_CMP: begin
                        // Compare: subtract for flags only, no register write
                        dp_known = 1'b1; dp_arith = 1'b1;
                        alu_control_d = ALU_SUB;
                    end
                    CMD_AND: begin
                        dp_known = 1'b1;
                        reg_write_d = 1'b1; alu_control_d = ALU_AND;
                    end
                    CMD_ORR: begin
                        dp_known = 1'b1;
                        reg_write_d = 1'b1; alu_control_d = ALU_ORR;
                    end
                    CMD_MOV: begin
                        dp_known = 1'b1;
                        reg_write_d = 1'b1; alu_control_d = ALU_MOV;
                    end
                    default: begin
                        // Unrecognised command: leave as a bubble
                        dp_known = 1'b0;
                    end
                endcase
                if (dp_known) begin
                    alu_src_d    = Funct[5];
                    flag_write_d = {Funct[0], Funct[0] & dp_arith};
                end
            end
            2'b01: begin
                // Funct[0] is the load bit: LDR writes a register, STR memory
                imm_src_d = 2'b01;
                alu_src_d = 1'b1;
                if (Funct[0]) begin
                    reg_write_d  = 1'b1;
                    mem_to_reg_d = 1'b1;
                end else begin
                    mem_write_d  = 1'b1;
                    reg_src_d    = 2'b10;
                end
            end
            2'b10: begin
                imm_src_d = 2'b10;
                reg_src_d = 2'b01;
                alu_src_d = 1'b1;
                branch_d  = 1'b1;
            end
            default: begin
                // Op=11 decodes as a bubble
                branch_d = 1'b0;
            end
        endcase

        pc_src_d = branch_d | (reg_write_d & (Rd == 4'hF));
    end

    assign ImmSrcD = imm_src_d;
    assign RegSrcD = reg_src_d;

    // ---------------- Decode -> Execute ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reg_write_p0   <= 1'b0;
            mem_write_p0   <= 1'b0;
            mem_to_reg_p0  <= 1'b0;
            branch_p0      <= 1'b0;
            alu_src_p0     <= 1'b0;
            pc_src_p0      <= 1'b0;
            flag_write_p0  <= 2'b00;
            alu_control_p0 <= '0;
        end else if (FlushE) begin
            reg_write_p0   <= 1'b0;
            mem_write_p0   <= 1'b0;
            mem_to_reg_p0  <= 1'b0;
            branch_p0      <= 1'b0;
            alu_src_p0     <= 1'b0;
            pc_src_p0      <= 1'b0;
            flag_write_p0  <= 2'b00;
            alu_control_p0 <= '0;
        end else if (!StallE) begin
            reg_write_p0   <= reg_write_d;
            mem_write_p0   <= mem_write_d;
            mem_to_reg_p0  <= mem_to_reg_d;
            branch_p0      <= branch_d;
            alu_src_p0     <= alu_src_d;
            pc_src_p0      <= pc_src_d;
            flag_write_p0  <= flag_write_d;
            alu_control_p0 <= alu_control_d;
        end
    end

`ifdef COND_EXEC_EN
    logic [3:0] cond_p0;

    // ARM condition codes against {N,Z,C,V}
    function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cond)
            4'b0000: cond_holds = z;
            4'b0001: cond_holds = ~z;
            4'b0010: cond_holds = c;
            4'b0011: cond_holds = ~c;
            4'b0100: cond_holds = n;
            4'b0101: cond_holds = ~n;
            4'b0110: cond_holds = v;
            4'b0111: cond_holds = ~v;
            4'b1000: cond_holds = c & ~z;
            4'b1001: cond_holds = ~c | z;
            4'b1010: cond_holds = (n == v);
            4'b1011: cond_holds = (n != v);
            4'b1100: cond_holds = ~z & (n == v);
            4'b1101: cond_holds = z | (n != v);
            4'b1110: cond_holds = 1'b1;
            default: cond_holds = 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cond_p0 <= 4'h0;
        end else if (FlushE) begin
            cond_p0 <= 4'h0;
        end else if (!StallE) begin
            cond_p0 <= Cond;
        end
    end

    assign cond_ex_e = cond_holds(cond_p0, flags_q[3:0]);
`else
    // Every instruction executes; Cond and the flag state are not consulted
    logic unused_cond;
    assign unused_cond = ^{Cond, flags_q};
    assign cond_ex_e   = 1'b1;
`endif

    // Flags written here are visible to the next instruction in Execute
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q <= '0;
        end else if (!StallE && !FlushE) begin
            if (flag_write_p0[1] && cond_ex_e) flags_q[3:2] <= ALUFlags[3:2];
            if (flag_write_p0[0] && cond_ex_e) flags_q[1:0] <= ALUFlags[1:0];
        end
    end

    assign ALUControlE  = alu_control_p0;
    assign ALUSrcE      = alu_src_p0;
    assign MemtoRegE    = mem_to_reg_p0;
    assign BranchTakenE = branch_p0 & cond_ex_e;

    // ---------------- Execute -> Memory ----------------
    // A stalled Execute instruction stays put, so a bubble goes downstream
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reg_write_p1  <= 1'b0;
            mem_write_p1  <= 1'b0;
            mem_to_reg_p1 <= 1'b0;
            pc_src_p1     <= 1'b0;
        end else if (StallE) begin
            reg_write_p1  <= 1'b0;
            mem_write_p1  <= 1'b0;
            mem_to_reg_p1 <= 1'b0;
            pc_src_p1     <= 1'b0;
        end else begin
            reg_write_p1  <= reg_write_p0 & cond_ex_e;
            mem_write_p1  <= mem_write_p0 & cond_ex_e;
            mem_to_reg_p1 <= mem_to_reg_p0;
            pc_src_p1     <= pc_src_p0 & cond_ex_e;
        end
    end

    assign RegWriteM = reg_write_p1;
    assign MemWriteM = mem_write_p1;
    assign MemtoRegM = mem_to_reg_p1;

    // ---------------- Memory -> Writeback ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reg_write_p2  <= 1'b0;
            mem_to_reg_p2 <= 1'b0;
            pc_src_p2     <= 1'b0;
        end else begin
            reg_write_p2  <= reg_write_p1;
            mem_to_reg_p2 <= mem_to_reg_p1;
            pc_src_p2     <= pc_src_p1;
        end
    end

    assign RegWriteW = reg_write_p2;
    assign MemtoRegW = mem_to_reg_p2;
    assign PCSrcW    = pc_src_p2;

    // Execute term is ungated so a possible PC write is reported early
    assign PCWrPending = pc_src_d | pc_src_p0 | pc_src_p1;

endmodule
